// File: rtl/ann_pkg.sv
// ann_pkg: shared widths, word type and feeder FSM states for the ANN frame feeder
package ann_pkg;
  localparam int DW = 10;
  localparam int N_FEAT = 30;
  localparam int N_OUT = 3;
  localparam int N_WORDS = N_FEAT + N_OUT;
  localparam int IW = $clog2(N_WORDS);
  typedef logic [DW-1:0] word_t;
  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {FILL_FEAT, FILL_TGT, SWAP_WAIT} feeder_state_t;
endpackage

// File: rtl/ann_frame_feeder_if.sv
// ann_frame_feeder_if: serial word stream in, parallel frame handshake out
interface ann_frame_feeder_if;
  import ann_pkg::*;
  logic train;
  logic s_valid;
  word_t s_data;
  logic s_last;
  logic s_ready;
  logic [N_FEAT*DW-1:0] feat_vec;
  logic [N_OUT*DW-1:0] tgt_vec;
  logic frame_train;
  logic frame_valid;
  logic frame_ack;
  logic [15:0] frame_cnt;
  logic err_sync;
  modport master (
    output train, s_valid, s_data, s_last, frame_ack,
    input s_ready, feat_vec, tgt_vec, frame_train, frame_valid, frame_cnt, err_sync
  );
  modport slave (
    input train, s_valid, s_data, s_last, frame_ack,
    output s_ready, feat_vec, tgt_vec, frame_train, frame_valid, frame_cnt, err_sync
  );
endinterface

// File: rtl/frame_bank.sv
// frame_bank: storage for one frame, feature words then target words, flat-packed
module frame_bank
  import ann_pkg::*;
(
  input logic Clock,
  input logic Rst,
  input logic we,
  input logic clr,
  input idx_t addr,
  input word_t wdata,
  output logic [N_WORDS*DW-1:0] q
);
  // clear wins over write so a recycled bank never leaks stale targets
  always_ff @(posedge Clock or negedge Rst)
    if (!Rst) q <= '0;
    else if (clr) q <= '0;
    else if (we) q[addr*DW +: DW] <= wdata;
endmodule

// File: rtl/ann_frame_feeder.sv
// ann_frame_feeder: double-buffered serial-to-frame assembler; FEEDER_SYNC_CHECK_EN enables s_last framing checks
module ann_frame_feeder
  import ann_pkg::*;
(
  input logic Clock,
  input logic Rst,
  ann_frame_feeder_if.slave s
);
  feeder_state_t state;
  idx_t idx;
  idx_t waddr;
  logic ptr;
  logic train_pend;
  logic xfer;
  logic last_word;
  logic err;
  logic swap;
  logic [1:0] we;
  logic [1:0] clr;
  logic [N_WORDS*DW-1:0] q [2];

  assign xfer = s.s_valid && s.s_ready;
  assign last_word = state == FILL_TGT ? idx == idx_t'(N_OUT-1)
                   : idx == idx_t'(N_FEAT-1) && !train_pend;
  assign swap = state == SWAP_WAIT && (!s.frame_valid || s.frame_ack);
  assign waddr = state == FILL_TGT ? idx + idx_t'(N_FEAT) : idx;
`ifdef FEEDER_SYNC_CHECK_EN
  assign err = xfer && (s.s_last != last_word);
`else
  assign err = 1'b0 & s.s_last;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = xfer && ptr == 1'(b);
    assign clr[b] = swap ? ptr != 1'(b) : err && ptr == 1'(b);
    frame_bank u_bank (
      .Clock(Clock),
      .Rst(Rst),
      .we(we[b]),
      .clr(clr[b]),
      .addr(waddr),
      .wdata(s.s_data),
      .q(q[b])
    );
  end

  assign s.feat_vec = q[~ptr][N_FEAT*DW-1:0];
  assign s.tgt_vec = q[~ptr][N_WORDS*DW-1 -: N_OUT*DW];

  // fill/target/swap sequencing plus the presented-frame handshake
  always_ff @(posedge Clock or negedge Rst)
    if (!Rst) begin
      state <= FILL_FEAT;
      idx <= '0;
      ptr <= 1'b0;
      train_pend <= 1'b0;
      s.s_ready <= 1'b0;
      s.frame_valid <= 1'b0;
      s.frame_train <= 1'b0;
      s.frame_cnt <= '0;
      s.err_sync <= 1'b0;
    end else begin
      s.err_sync <= err;
      if (s.frame_ack && s.frame_valid) s.frame_valid <= 1'b0;
      if (err) begin
        state <= FILL_FEAT;
        idx <= '0;
        s.s_ready <= 1'b1;
      end else case (state)
        FILL_FEAT: begin
          s.s_ready <= 1'b1;
          if (xfer) begin
            if (idx == '0) train_pend <= s.train;
            if (idx == idx_t'(N_FEAT-1)) begin
              idx <= '0;
              state <= train_pend ? FILL_TGT : SWAP_WAIT;
              s.s_ready <= train_pend;
            end else idx <= idx + idx_t'(1);
          end
        end
        FILL_TGT: begin
          s.s_ready <= 1'b1;
          if (xfer) begin
            idx <= last_word ? '0 : idx + idx_t'(1);
            state <= last_word ? SWAP_WAIT : FILL_TGT;
            s.s_ready <= !last_word;
          end
        end
        SWAP_WAIT: begin
          if (swap) begin
            ptr <= ~ptr;
            s.frame_valid <= 1'b1;
            s.frame_train <= train_pend;
            s.frame_cnt <= s.frame_cnt + 16'd1;
            state <= FILL_FEAT;
            s.s_ready <= 1'b1;
          end
        end
        default: state <= FILL_FEAT;
      endcase
    end
endmodule

// File: tb/tb_ann_frame_feeder.sv
// tb_ann_frame_feeder: scoreboard bench for ann_frame_feeder
module tb_ann_frame_feeder;
  import ann_pkg::*;
  typedef struct {
    logic [N_FEAT*DW-1:0] f;
    logic [N_OUT*DW-1:0] t;
    logic tr;
  } frame_t;

  logic Clock = 1'b0;
  logic Rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  frame_t sb[$];
  frame_t cur;
  bit have_cur = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] seen_cnt = '0;

  ann_frame_feeder_if ff();
  ann_frame_feeder dut (.Clock(Clock), .Rst(Rst), .s(ff));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  function automatic logic [N_FEAT*DW-1:0] ramp(input int base, input int step);
    logic [N_FEAT*DW-1:0] v;
    for (int i = 0; i < N_FEAT; i++) v[i*DW +: DW] = word_t'(base + i*step);
    return v;
  endfunction

  function automatic logic [N_FEAT*DW-1:0] rnd_feat();
    logic [N_FEAT*DW-1:0] v;
    for (int i = 0; i < N_FEAT; i++) v[i*DW +: DW] = word_t'($urandom);
    return v;
  endfunction

  function automatic logic [N_OUT*DW-1:0] rnd_tgt();
    logic [N_OUT*DW-1:0] v;
    for (int i = 0; i < N_OUT; i++) v[i*DW +: DW] = word_t'($urandom);
    return v;
  endfunction

  task automatic send(input word_t d, input logic l, input logic t);
    int b = 0;
    ff.s_valid = 1'b1;
    ff.s_data = d;
    ff.s_last = l;
    ff.train = t;
    while (!ff.s_ready && b < 200) begin
      @(negedge Clock);
      b++;
    end
    if (b >= 200) chk("ready_timeout", b, 0);
    @(negedge Clock);
    ff.s_valid = 1'b0;
    ff.s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [N_FEAT*DW-1:0] f, input logic [N_OUT*DW-1:0] t, input logic tr);
    for (int i = 0; i < N_FEAT; i++) send(f[i*DW +: DW], !tr && i == N_FEAT-1, i == 0 ? tr : ~tr);
    if (tr) for (int i = 0; i < N_OUT; i++) send(t[i*DW +: DW], i == N_OUT-1, ~tr);
    sb.push_back('{f, tr ? t : {N_OUT*DW{1'b0}}, tr});
  endtask

  task automatic ack();
    ff.frame_ack = 1'b1;
    cyc(1);
    ff.frame_ack = 1'b0;
  endtask

  // pop the scoreboard on every new frame and hold presented data to the model
  always @(negedge Clock) begin
    if (!Rst) begin
      have_cur = 0;
      seen_cnt = '0;
      exp_cnt = '0;
    end else begin
      if (ff.frame_cnt != seen_cnt) begin
        seen_cnt = ff.frame_cnt;
        exp_cnt = exp_cnt + 16'd1;
        chk("frame_cnt_step", ff.frame_cnt, exp_cnt);
        chk("present_valid", ff.frame_valid, 1);
        chk("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          have_cur = 1;
        end
      end
      if (ff.frame_valid && have_cur) begin
        chk("feat_vec", ff.feat_vec, cur.f);
        chk("tgt_vec", ff.tgt_vec, cur.t);
        chk("frame_train", ff.frame_train, cur.tr);
      end
    end
  end

  initial begin
    ff.s_valid = 1'b0;
    ff.s_data = '0;
    ff.s_last = 1'b0;
    ff.train = 1'b0;
    ff.frame_ack = 1'b0;
    cyc(2);
    chk("rst_s_ready", ff.s_ready, 0);
    chk("rst_valid", ff.frame_valid, 0);
    chk("rst_feat", ff.feat_vec, 0);
    chk("rst_tgt", ff.tgt_vec, 0);
    chk("rst_train", ff.frame_train, 0);
    chk("rst_cnt", ff.frame_cnt, 0);
    chk("rst_err", ff.err_sync, 0);
    Rst = 1'b1;
    chk("ready_before_edge", ff.s_ready, 0);
    cyc(1);
    chk("ready_after_rst", ff.s_ready, 1);

    send_frame(ramp(1, 1), '0, 1'b0);
    chk("lat_t_valid", ff.frame_valid, 0);
    chk("lat_t_ready", ff.s_ready, 0);
    cyc(1);
    chk("lat_t1_valid", ff.frame_valid, 1);
    chk("lat_t1_ready", ff.s_ready, 1);
    chk("f1_cnt", ff.frame_cnt, 1);
    chk("f1_w0", ff.feat_vec[DW-1:0], 1);
    chk("f1_w29", ff.feat_vec[N_FEAT*DW-1 -: DW], 30);
    chk("f1_tgt", ff.tgt_vec, 0);
    ack();
    chk("ack_clear", ff.frame_valid, 0);
    ack();
    chk("idle_ack_valid", ff.frame_valid, 0);
    chk("idle_ack_cnt", ff.frame_cnt, 1);

    send_frame(ramp(100, 1), {10'd1000, 10'd0, 10'd900}, 1'b1);
    chk("tr_gap", ff.s_ready, 0);
    cyc(1);
    chk("tr_ready", ff.s_ready, 1);
    chk("tr_train", ff.frame_train, 1);
    chk("tr_tgt", ff.tgt_vec, {10'd1000, 10'd0, 10'd900});

    send_frame(ramp(7, 3), '0, 1'b0);
    repeat (4) begin
      cyc(1);
      chk("hold_ready", ff.s_ready, 0);
      chk("hold_cnt", ff.frame_cnt, 2);
    end
    ack();
    chk("swap_valid", ff.frame_valid, 1);
    chk("swap_cnt", ff.frame_cnt, 3);
    chk("swap_tgt_cleared", ff.tgt_vec, 0);

    send_frame(ramp(333, -5), '0, 1'b0);
    ack();
    chk("nogap_valid", ff.frame_valid, 1);
    chk("nogap_cnt", ff.frame_cnt, 4);

    for (int k = 0; k < 4; k++) begin
      ack();
      send_frame(rnd_feat(), rnd_tgt(), 1'($urandom));
    end
    cyc(2);
    ack();
    chk("rand_cnt", ff.frame_cnt, 8);

    for (int i = 0; i < 17; i++) send(word_t'(40 + i), 1'b0, 1'b0);
    Rst = 1'b0;
    sb.delete();
    cyc(1);
    chk("mid_rst_valid", ff.frame_valid, 0);
    chk("mid_rst_feat", ff.feat_vec, 0);
    chk("mid_rst_cnt", ff.frame_cnt, 0);
    chk("mid_rst_ready", ff.s_ready, 0);
    Rst = 1'b1;
    cyc(1);
    send_frame(ramp(500, 0), '0, 1'b0);
    cyc(1);
    chk("r_cnt", ff.frame_cnt, 1);
    chk("r_w0", ff.feat_vec[DW-1:0], 500);
    chk("r_w29", ff.feat_vec[N_FEAT*DW-1 -: DW], 500);

`ifdef FEEDER_SYNC_CHECK_EN
    ack();
    for (int i = 0; i < 12; i++) send(word_t'(60 + i), i == 11, 1'b0);
    chk("err_pulse", ff.err_sync, 1);
    chk("err_ready", ff.s_ready, 1);
    cyc(1);
    chk("err_clear", ff.err_sync, 0);
    chk("err_cnt", ff.frame_cnt, 1);
    send_frame(ramp(11, 2), '0, 1'b0);
    cyc(1);
    chk("post_err_cnt", ff.frame_cnt, 2);
    chk("post_err_w0", ff.feat_vec[DW-1:0], 11);
    chk("post_err_err", ff.err_sync, 0);
`else
    chk("err_tied", ff.err_sync, 0);
`endif

    cyc(3);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/ann_frame_feeder.md
Name: ann_frame_feeder

Overview:
- Producer side of the detector's parallel feature-vector interface.
- Accepts a serial stream of 10-bit feature words, plus training targets in train mode, and assembles them into a 30-word feature vector and a 3-word target vector.
- Presents each completed frame to the ANN core with a valid/ack handshake.
- Double-buffered: one bank fills while the other is held stable for the core.

Parameters:
- DW, 10, word width in bits.
- N_FEAT, 30, feature words per frame.
- N_OUT, 3, target words per frame in train mode.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous active-low reset.
- train  in  1  mode select; sampled on the first accepted word of each frame.
- s_valid  in  1  input word valid.
- s_data  in  DW  input word.
- s_last  in  1  marks the final word of a frame; used only with FEEDER_SYNC_CHECK_EN.
- s_ready  out  1  feeder can accept a word.
- feat_vec  out  N_FEAT*DW  presented feature vector; word i at bits [i*DW +: DW].
- tgt_vec  out  N_OUT*DW  presented target vector; zero for inference frames.
- frame_train  out  1  presented frame carries targets.
- frame_valid  out  1  presented frame is ready for the core.
- frame_ack  in  1  core has consumed the presented frame.
- frame_cnt  out  16  frames delivered; wraps from 0xFFFF to 0.
- err_sync  out  1  one-cycle pulse on a framing error (feature builds only).

Behaviour:
- Reset (Rst low, asynchronous):
  - Outputs: s_ready=0, frame_valid=0, feat_vec=0, tgt_vec=0, frame_train=0, frame_cnt=0, err_sync=0.
  - Internal: both banks cleared, write index=0, state=FILL_FEAT.
  - Reset asserted mid-frame discards all partial and presented data.
  - s_ready rises on the first clock edge after Rst deasserts.
- A word transfers on a posedge with s_valid and s_ready both high. Data passes through unmodified; no arithmetic on data.
- FSM states:
  - FILL_FEAT: s_ready=1. Each transfer writes bank[wr][idx] and increments idx.
    - When word index 0 transfers, train is latched as frame_train_pending.
    - When idx=N_FEAT-1 transfers: go to FILL_TGT if train was latched, else to SWAP_WAIT; idx returns to 0.
  - FILL_TGT: s_ready=1. Writes target words 0..N_OUT-1. After word N_OUT-1, go to SWAP_WAIT.
  - SWAP_WAIT: s_ready=0.
    - If frame_valid=0, or frame_ack=1 in the same cycle: the fill bank becomes the presented bank, frame_valid=1, frame_cnt increments, state returns to FILL_FEAT.
    - Otherwise stay.
- Latency:
  - The final word accepted at edge t gives frame_valid=1 after edge t+1 if the presenter is free.
  - Back-to-back frames lose exactly one cycle of s_ready per frame.
- Presented side:
  - feat_vec, tgt_vec and frame_train are constant while frame_valid=1.
  - frame_ack while frame_valid=1 clears frame_valid at the next edge, unless a swap loads a new frame in that same edge.
  - frame_ack while frame_valid=0 is ignored.
- Changes to train in mid-frame have no effect on the frame in progress.
- The feeder never drops a word while s_ready=1 (no overflow condition).

Optional Feature:
- FEEDER_SYNC_CHECK_EN defined:
  - A framing error occurs when s_last=1 on any word other than the final word of a frame, or s_last=0 on the final word.
  - On an error: the partial frame is discarded, idx returns to 0, state goes to FILL_FEAT, and err_sync pulses for one cycle.
  - An erroneous frame is never presented. A word carrying an early s_last is treated as the end of the discarded frame.
- Not defined: s_last is ignored and err_sync is tied to 0.

Decomposition:
- Package ann_pkg holds:
  - DW, N_FEAT, N_OUT constants.
  - word_t typedef, logic [DW-1:0].
  - feeder_state_t enum {FILL_FEAT, FILL_TGT, SWAP_WAIT}.
- One sub-module, frame_bank: the storage for one frame (N_FEAT+N_OUT words) with write enable, write index and clear.
  - Instantiated twice.
  - A 1-bit pointer selects the fill bank and the presented bank.

Test Plan:
- Reset release, train=0, stream words 1..30, no ack → frame_valid=1 one cycle after word 30; feat_vec word i = i+1; tgt_vec=0; frame_cnt=1.
- train=1, words 100..129 followed by targets 900, 0, 1000 → frame_train=1, tgt_vec = {1000, 0, 900}, i.e. word 0 = 900; s_ready low for 1 cycle only.
- Present frame A without ack, then stream frame B → s_ready stays 0 after B's last word; ack A → B presented the next cycle; feat_vec is stable while A is presented; frame_cnt=2.
- Ack in the same cycle B completes → B presented at the next edge with no frame_valid gap.
- Rst pulsed low after 17 words, then a full frame of 500s → only the 500s frame is presented; frame_cnt=1.
- FEEDER_SYNC_CHECK_EN defined, s_last on word 12 → err_sync pulses once; the next well-formed frame is presented correctly; frame_cnt is unchanged by the bad frame.
